// File: rtl/seq_11010_tx_if.sv
// -----------------------------------------------------------------------------
// seq_11010_tx_if
// Handshake and serial-data bundle for the 11010 pattern transmitter.
//
// Signals:
//   start   - burst request from the controller
//   reps    - number of 11010 frames in the burst (REP_W bits)
//   abort   - synchronous cancel of a running burst
//   d_out   - serial data bit toward the detector
//   d_valid - d_out carries a pattern bit this cycle
//   busy    - transmitter is not idle
//   done    - one-cycle pulse on normal burst completion
//
// Modports:
//   master - controller / testbench side (drives start, reps, abort)
//   slave  - transmitter side (drives d_out, d_valid, busy, done)
// -----------------------------------------------------------------------------
interface seq_11010_tx_if #(
    parameter int REP_W = 4
);
    logic             start;
    logic [REP_W-1:0] reps;
    logic             abort;
    logic             d_out;
    logic             d_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, reps, abort,
        input  d_out, d_valid, busy, done
    );

    modport slave (
        input  start, reps, abort,
        output d_out, d_valid, busy, done
    );
endinterface

// File: rtl/seq_11010_tx.sv
// -----------------------------------------------------------------------------
// seq_11010_tx
// Serial pattern transmitter: sends the frame 1-1-0-1-0 on a one-bit line, one
// bit per clock, repeated `reps` times per burst. Source end of the 11010
// serial link; d_out feeds the 11010 Mealy detector.
//
// Ports:
//   clk      - single clock, rising edge
//   reset_n  - asynchronous active-low reset
//   bus      - seq_11010_tx_if.slave (start, reps, abort in;
//              d_out, d_valid, busy, done out)
//
// Parameters:
//   REP_W    - width of the repetition count
//   GAP_LEN  - idle zero bits between frames (1..15), used with SEQ_TX_GAP_EN
//
// Build option:
//   SEQ_TX_GAP_EN - when defined, frames are separated by GAP_LEN idle cycles
//                   (d_valid=0). When undefined, frames go back-to-back so the
//                   detector sees overlapping patterns.
//
// The state register is Gray-coded to match the detector side. All outputs
// are Moore, decoded from the state register only, so an asynchronous reset
// clears them immediately.
// -----------------------------------------------------------------------------
module seq_11010_tx #(
    parameter int REP_W   = 4,
    parameter int GAP_LEN = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    seq_11010_tx_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        B1   = 3'b001,
        B2   = 3'b011,
        B3   = 3'b010,
        B4   = 3'b110,
        B5   = 3'b111,
        GAP  = 3'b101,
        DONE = 3'b100
    } state_t;

    localparam logic [REP_W-1:0] REP_ONE  = {{(REP_W-1){1'b0}}, 1'b1};
    localparam logic [REP_W-1:0] REP_ZERO = '0;

    // Elaboration-time guard on the gap length range.
    if (GAP_LEN < 1 || GAP_LEN > 15) begin : g_gap_len_check
        $error("seq_11010_tx: GAP_LEN must be in 1..15");
    end

    state_t           state_q, state_d;
    logic [REP_W-1:0] rem_cnt_q, rem_cnt_d;

`ifdef SEQ_TX_GAP_EN
    localparam logic [3:0] GAP_LOAD = 4'(GAP_LEN - 1);

    logic [3:0] gap_cnt_q, gap_cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gap_cnt_q <= 4'd0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rem_cnt_q <= REP_ZERO;
        end else begin
            state_q   <= state_d;
            rem_cnt_q <= rem_cnt_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d   = state_q;
        rem_cnt_d = rem_cnt_q;
`ifdef SEQ_TX_GAP_EN
        gap_cnt_d = gap_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.reps != REP_ZERO) begin
                        rem_cnt_d = bus.reps;
                        state_d   = B1;
                    end else begin
                        // Zero-length burst still reports completion.
                        state_d = DONE;
                    end
                end
            end
            B1: state_d = B2;
            B2: state_d = B3;
            B3: state_d = B4;
            B4: state_d = B5;
            B5: begin
                // rem_cnt is at least 1 here; guard keeps it from wrapping.
                if (rem_cnt_q != REP_ZERO) begin
                    rem_cnt_d = rem_cnt_q - REP_ONE;
                end
                if (rem_cnt_q <= REP_ONE) begin
                    state_d = DONE;
                end else begin
`ifdef SEQ_TX_GAP_EN
                    gap_cnt_d = GAP_LOAD;
                    state_d   = GAP;
`else
                    state_d   = B1;
`endif
                end
            end
`ifdef SEQ_TX_GAP_EN
            GAP: begin
                // Counter runs GAP_LEN-1 down to 0, giving GAP_LEN idle cycles.
                if (gap_cnt_q == 4'd0) begin
                    state_d = B1;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort overrides every other transition once a burst is underway.
        if (bus.abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    // Moore output decode.
    always_comb begin
        bus.d_out   = 1'b0;
        bus.d_valid = 1'b0;
        bus.busy    = (state_q != IDLE);
        bus.done    = 1'b0;
        case (state_q)
            B1: begin
                bus.d_out   = 1'b1;
                bus.d_valid = 1'b1;
            end
            B2: begin
                bus.d_out   = 1'b1;
                bus.d_valid = 1'b1;
            end
            B3: begin
                bus.d_valid = 1'b1;
            end
            B4: begin
                bus.d_out   = 1'b1;
                bus.d_valid = 1'b1;
            end
            B5: begin
                bus.d_valid = 1'b1;
            end
            DONE: begin
                bus.done = 1'b1;
            end
            default: begin
                bus.d_out   = 1'b0;
                bus.d_valid = 1'b0;
            end
        endcase
    end

endmodule
